div_sequencer: RTL and testbench

Transaction front-end for the iterative 32-bit restoring divider core. It accepts operands over a valid/ready handshake, latches them, and pulses the core's clear. It then counts the core's fixed iteration latency, captures quotient and remainder, and presents them downstream over a second valid/ready handshake. Divide-by-zero is resolved locally without running the core.

---
 rtl/div_sequencer.sv | 151 +++++++++++++++
 tb/tb_div_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: valid/ready transaction front-end for the iterative restoring divider core.
// Latency: result valid CORE_LAT+2 cycles after the accept edge (1 cycle on divide-by-zero).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, r                      clock and asynchronous active-low reset
//   in_valid/in_ready           operand request handshake (in_dividend, in_divisor)
//   out_valid/out_ready         result handshake (out_quotient, out_remainder, out_dbz)
//   core_clr, core_dend/dsor    clear pulse and held operands towards the divider core
//   core_quotient/remainder     raw results from the divider core
// Optional feature: define SIGNED_DIV_EN to add the in_signed port and the signed fixup
// wrapped around the unsigned core. Without it all operations are unsigned.

module div_sequencer #(
   parameter int WIDTH    = 32,
   parameter int CORE_LAT = 34
) (
   input  logic             clk,
   input  logic             r,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
`ifdef SIGNED_DIV_EN
   input  logic             in_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dbz,
   output logic             core_clr,
   output logic [WIDTH-1:0] core_dend,
   output logic [WIDTH-1:0] core_dsor,
   input  logic [WIDTH-1:0] core_quotient,
   input  logic [WIDTH-1:0] core_remainder
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter value seen in the last RUN cycle, when the core result is stable.
   localparam logic [5:0] LAST_CNT = 6'(CORE_LAT - 1);

   state_t           state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] dend_mag;
   logic [WIDTH-1:0] dsor_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

`ifdef SIGNED_DIV_EN
   logic dend_neg;
   logic dsor_neg;
   logic neg_q;   // quotient must be negated at capture
   logic neg_r;   // remainder must be negated at capture

   // The core only divides magnitudes; the signs are remembered and applied on capture.
   // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
   assign dend_neg = in_signed & in_dividend[WIDTH-1];
   assign dsor_neg = in_signed & in_divisor[WIDTH-1];
   assign dend_mag = dend_neg ? -in_dividend : in_dividend;
   assign dsor_mag = dsor_neg ? -in_divisor  : in_divisor;
   assign q_fix    = neg_q ? -core_quotient  : core_quotient;
   assign r_fix    = neg_r ? -core_remainder : core_remainder;
`else
   assign dend_mag = in_dividend;
   assign dsor_mag = in_divisor;
   assign q_fix    = core_quotient;
   assign r_fix    = core_remainder;
`endif

   // Only output that is not a register: acceptance follows the state directly.
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state         <= IDLE;
         cnt           <= '0;
         core_clr      <= 1'b0;
         core_dend     <= '0;
         core_dsor     <= '0;
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  core_dend <= dend_mag;
                  core_dsor <= dsor_mag;
`ifdef SIGNED_DIV_EN
                  neg_q     <= dend_neg ^ dsor_neg;
                  neg_r     <= dend_neg;
`endif
                  if (in_divisor == '0) begin
                     // Resolved locally: the core is never cleared or started.
                     out_quotient  <= '1;
                     out_remainder <= in_dividend;
                     out_dbz       <= 1'b1;
                     out_valid     <= 1'b1;
                     state         <= DONE;
                  end else begin
                     core_clr <= 1'b1;
                     state    <= CLEAR;
                  end
               end
            end

            CLEAR: begin
               core_clr <= 1'b0;
               cnt      <= '0;
               state    <= RUN;
            end

            RUN: begin
               cnt <= cnt + 6'd1;
               if (cnt == LAST_CNT) begin
                  out_quotient  <= q_fix;
                  out_remainder <= r_fix;
                  out_dbz       <= 1'b0;
                  out_valid     <= 1'b1;
                  state         <= DONE;
               end
            end

            DONE: begin
               // Returning to IDLE first means no acceptance in the handshake cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized self-checking bench for div_sequencer with a behavioural
// divider core model that only presents a correct result once its latency has elapsed.
// Checks timing of clear/valid, result values, hold under backpressure and reset recovery.

module tb_div_sequencer;

   localparam int W   = 32;
   localparam int LAT = 34;
`ifdef SIGNED_DIV_EN
   localparam bit HAS_SIGNED = 1'b1;
`else
   localparam bit HAS_SIGNED = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         r   = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_dividend = '0;
   logic [W-1:0] in_divisor  = '0;
`ifdef SIGNED_DIV_EN
   logic         in_signed = 1'b0;
`endif
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_remainder;
   logic         out_dbz;
   logic         core_clr;
   logic [W-1:0] core_dend;
   logic [W-1:0] core_dsor;
   logic [W-1:0] core_quotient;
   logic [W-1:0] core_remainder;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   div_sequencer #(.WIDTH(W), .CORE_LAT(LAT)) dut (
      .clk            (clk),
      .r              (r),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_dividend    (in_dividend),
      .in_divisor     (in_divisor),
`ifdef SIGNED_DIV_EN
      .in_signed      (in_signed),
`endif
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_quotient   (out_quotient),
      .out_remainder  (out_remainder),
      .out_dbz        (out_dbz),
      .core_clr       (core_clr),
      .core_dend      (core_dend),
      .core_dsor      (core_dsor),
      .core_quotient  (core_quotient),
      .core_remainder (core_remainder)
   );

   // Divider core model: garbage until LAT-1 cycles after the clear cycle, then a/b.
   int ccnt = 0;
   always @(posedge clk) begin
      if (core_clr)        ccnt <= 0;
      else if (ccnt < LAT) ccnt <= ccnt + 1;
   end

   always_comb begin
      core_quotient  = 32'hDEAD_BEEF ^ 32'(ccnt);
      core_remainder = 32'h0BAD_F00D ^ 32'(ccnt);
      if (ccnt >= LAT - 1 && core_dsor != '0) begin
         core_quotient  = core_dend / core_dsor;
         core_remainder = core_dend % core_dsor;
      end
   end

   // Clear-pulse monitor.
   int clr_cnt = 0;
   int clr_cyc = -1;
   always @(negedge clk) begin
      if (core_clr) begin
         clr_cnt = clr_cnt + 1;
         clr_cyc = cyc;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: plain integer division, 64-bit wide so the signed overflow case is exact.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                   output logic [31:0] q, output logic [31:0] rm,
                                   output logic dbz);
      longint sa, sb;
      if (b == 32'd0) begin
         q   = 32'hFFFF_FFFF;
         rm  = a;
         dbz = 1'b1;
      end else if (sg) begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         q   = 32'(sa / sb);
         rm  = 32'(sa % sb);
         dbz = 1'b0;
      end else begin
         q   = a / b;
         rm  = a % b;
         dbz = 1'b0;
      end
   endfunction

   int last_acc = 0;

   // One full transaction starting in a cycle where the DUT should be idle.
   task automatic txn(input logic [31:0] a, input logic [31:0] b, input bit sg_req,
                      input int stall, input int exp_gap);
      logic [31:0] eq, er, edsor;
      logic        ed;
      bit          sg, seen;
      int          acc, clr0, lat;
      sg = sg_req & HAS_SIGNED;
      ref_div(a, b, sg, eq, er, ed);
      edsor = (sg && b[31]) ? -b : b;
      chk("in_ready_idle", in_ready, 1'b1);
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
`ifdef SIGNED_DIV_EN
      in_signed   = sg;
`endif
      out_ready   = (stall == 0);
      clr0        = clr_cnt;
      @(posedge clk); #1;
      // Scramble the inputs so that results depend on latched operands only.
      in_valid    = 1'b0;
      in_dividend = $urandom;
      in_divisor  = $urandom;
`ifdef SIGNED_DIV_EN
      in_signed   = ~sg;
`endif
      acc = cyc;
      if (exp_gap > 0) chk("accept_gap", acc - last_acc, exp_gap);
      last_acc = acc;
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_rise", seen, 1'b1);
      chk("latency", lat, ed ? 0 : LAT + 1);
      chk("clr_pulses", clr_cnt - clr0, ed ? 0 : 1);
      if (!ed) chk("clr_cycle", clr_cyc, acc);
      chk("quotient", out_quotient, eq);
      chk("remainder", out_remainder, er);
      chk("dbz", out_dbz, ed);
      chk("core_dsor", core_dsor, edsor);
      chk("in_ready_busy", in_ready, 1'b0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_result", {out_quotient, out_remainder}, {eq, er});
         chk("hold_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_valid", out_valid, 1'b0);
      chk("post_ready", in_ready, 1'b1);
   endtask

   initial begin
      bit          any_valid;
      logic [31:0] ra, rb;
      int          sel;

      // Power-on reset.
      #2 r = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_ready", in_ready, 1'b1);
      chk("reset_clr", core_clr, 1'b0);
      chk("reset_result", {out_quotient, out_remainder}, 64'd0);
      chk("reset_dbz", out_dbz, 1'b0);
      chk("reset_core_ops", {core_dend, core_dsor}, 64'd0);
      r = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      txn(32'd108, 32'd31, 1'b0, 0, 0);
      txn(32'd5, 32'd0, 1'b0, 0, 0);
      txn(32'd1000, 32'd7, 1'b0, 10, 0);
      txn(32'd100, 32'd10, 1'b0, 0, 0);
      txn(32'd7, 32'd3, 1'b0, 0, LAT + 3);

      // Reset in RUN cycle 10 discards the transaction.
      in_valid    = 1'b1;
      in_dividend = 32'd108;
      in_divisor  = 32'd31;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #2 r = 1'b0;
      #1;
      chk("midrun_rst_valid", out_valid, 1'b0);
      chk("midrun_rst_clr", core_clr, 1'b0);
      chk("midrun_rst_result", {out_quotient, out_remainder}, 64'd0);
      chk("midrun_rst_dbz", out_dbz, 1'b0);
      chk("midrun_rst_core_ops", {core_dend, core_dsor}, 64'd0);
      @(posedge clk); #1;
      r = 1'b1;
      @(posedge clk); #1;
      chk("midrun_rst_ready", in_ready, 1'b1);
      any_valid = 1'b0;
      for (int i = 0; i < LAT + 6; i++) begin
         any_valid |= out_valid;
         @(posedge clk); #1;
      end
      chk("midrun_no_stale_result", any_valid, 1'b0);
      txn(32'd9, 32'd2, 1'b0, 0, 0);

`ifdef SIGNED_DIV_EN
      txn(32'hFFFF_FF94, 32'd31, 1'b1, 0, 0);
      txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2, 0);
      txn(32'hFFFF_FF94, 32'd0, 1'b1, 1, 0);
      txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
`endif

      // Randomized transactions.
      for (int k = 0; k < 40; k++) begin
         ra  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0)     rb = 32'd0;
         else if (sel < 4) rb = $urandom_range(1, 300);
         else              rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
         txn(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
